// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUOp encodings and multiply/divide sequencer state encoding
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULTU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_MFHI  = 4'd13,
        OP_MFLO  = 4'd14,
        OP_NOP   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand/result bundle between the ALU and its user
interface alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OPW-1:0]   ALUOp;
    logic             start;
    logic [WIDTH-1:0] C;
    logic             Zero;
    logic             busy;
    logic             done;

    modport master (output A, B, ALUOp, start, input C, Zero, busy, done);
    modport slave  (input A, B, ALUOp, start, output C, Zero, busy, done);
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned multiply/divide, one bit per cycle, owns HI/LO
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_d;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_acc_d;
    logic                 last_iter;
    logic                 is_mul;
    logic                 is_div;

    // acc_q is {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_sh >= {1'b0, b_q};
    assign div_diff  = div_sh[WIDTH-1:0] - b_q;
    assign div_acc_d = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign is_mul    = (op_i == OPW'(OP_MULTU));
    assign is_div    = (op_i == OPW'(OP_DIVU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && (is_mul || is_div)) begin
                        acc_q   <= {{WIDTH{1'b0}}, a_i};
                        b_q     <= b_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= is_mul ? S_MUL : S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= (state_q == S_MUL) ? mul_acc_d : div_acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    hi_q    <= acc_q[2*WIDTH-1:WIDTH];
                    lo_q    <= acc_q[WIDTH-1:0];
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle ALU ops plus HI/LO moves around the iterative mul/div unit
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [SW-1:0]    shamt;

    assign shamt = bus.B[SW-1:0];

    muldiv_seq #(.WIDTH(WIDTH), .OPW(OPW)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.start),
        .op_i    (bus.ALUOp),
        .a_i     (bus.A),
        .b_i     (bus.B),
        .hi_o    (hi),
        .lo_o    (lo),
        .busy_o  (bus.busy),
        .done_o  (bus.done)
    );

    assign bus.Zero = (bus.A == bus.B);

    always_comb begin
        bus.C = bus.A;
        case (bus.ALUOp)
            OPW'(OP_ADD):   bus.C = bus.A + bus.B;
            OPW'(OP_SUB):   bus.C = bus.A - bus.B;
            OPW'(OP_AND):   bus.C = bus.A & bus.B;
            OPW'(OP_OR):    bus.C = bus.A | bus.B;
            OPW'(OP_XOR):   bus.C = bus.A ^ bus.B;
            OPW'(OP_NOR):   bus.C = ~(bus.A | bus.B);
            OPW'(OP_SLT):   bus.C = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OPW'(OP_SLTU):  bus.C = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OPW'(OP_SLL):   bus.C = bus.A << shamt;
            OPW'(OP_SRL):   bus.C = bus.A >> shamt;
            OPW'(OP_SRA):   bus.C = WIDTH'($signed(bus.A) >>> shamt);
            OPW'(OP_MULTU): bus.C = '0;
            OPW'(OP_DIVU):  bus.C = '0;
            OPW'(OP_MFHI):  bus.C = hi;
            OPW'(OP_MFLO):  bus.C = lo;
            default:        bus.C = bus.A;
        endcase
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - randomized scoreboard bench for alu_muldiv against an arithmetic model
module tb_alu_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_muldiv_if #(.WIDTH(W), .OPW(4)) bus ();
    alu_muldiv #(.WIDTH(W), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [W-1:0] c;
        bit           cz;
        bit           z;
        bit           cb;
        bit           b;
    } crec_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } drec_t;

    crec_t cq[$];
    drec_t dq[$];
    crec_t mr;
    drec_t md;
    int cyc = 0;
    int busy_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        int sh;
        sh = int'(b % W);
        r = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r[0] = (a[W-1] != b[W-1]) ? a[W-1] : (a < b);
            4'd7:  r[0] = (a < b);
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
            4'd11, 4'd12: r = '0;
            4'd13: r = m_hi;
            4'd14: r = m_lo;
            default: r = a;
        endcase
        return r;
    endfunction

    // scoreboard monitor: drains combinational expectations and matches done pulses
    always @(negedge clk) begin
        while (cq.size() > 0) begin
            mr = cq.pop_front();
            chk({mr.nm, " C"}, 64'(bus.C), 64'(mr.c));
            if (mr.cz) chk({mr.nm, " Zero"}, 64'(bus.Zero), 64'(mr.z));
            if (mr.cb) begin
                chk({mr.nm, " busy"}, 64'(bus.busy), 64'(mr.b));
                chk({mr.nm, " done"}, 64'(bus.done), 64'(0));
            end
        end
        if (rst) busy_cnt = 0;
        else if (bus.busy) busy_cnt++;
        if (bus.done) begin
            if (dq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected done: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                md = dq.pop_front();
                chk("done cycle", 64'(cyc), 64'(md.cyc));
                chk("busy cycles", 64'(busy_cnt), 64'(W));
                m_hi = md.hi;
                m_lo = md.lo;
            end
            busy_cnt = 0;
        end
    end

    task automatic drive(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic st, input logic [W-1:0] ec,
                         input bit cz, input bit cb, input bit eb);
        crec_t r;
        bus.ALUOp = op;
        bus.A = a;
        bus.B = b;
        bus.start = st;
        r.nm = nm; r.c = ec; r.cz = cz; r.z = (a == b); r.cb = cb; r.b = eb;
        cq.push_back(r);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic comb(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        drive(nm, op, a, b, 1'b0, ref_alu(op, a, b), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic launch(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        drec_t d;
        logic [2*W-1:0] p;
        if (op == 4'd11) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            d.hi = p[2*W-1:W];
            d.lo = p[W-1:0];
        end else if (b == 0) begin
            d.hi = a;
            d.lo = '1;
        end else begin
            d.hi = a % b;
            d.lo = a / b;
        end
        d.cyc = cyc + 1 + W;
        dq.push_back(d);
        drive({nm, " issue"}, op, a, b, 1'b1, '0, 1'b1, 1'b1, 1'b0);
        drive({nm, " iter"}, op, $urandom, $urandom, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100 && dq.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (dq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: got no done expected done within 100 cycles", nm);
            dq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [W-1:0] a, b;
        bus.A = '0; bus.B = '0; bus.ALUOp = 4'd15; bus.start = 1'b0;
        @(posedge clk); #1;

        drive("reset MFHI", 4'd13, 32'h1234, 32'h5678, 1'b1, '0, 1'b1, 1'b1, 1'b0);
        drive("reset MFLO", 4'd14, 32'h1, 32'h1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;

        launch("mul first edge", 4'd11, 32'd3, 32'd5);
        wait_done("mul first edge");
        drive("mul3x5 MFLO", 4'd14, 0, 0, 1'b0, 32'd15, 1'b0, 1'b1, 1'b0);

        drive("SRA", 4'd10, 32'h80000010, 32'd4, 1'b0, 32'hF8000001, 1'b0, 1'b0, 1'b0);
        drive("SLT", 4'd6, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
        drive("SLTU", 4'd7, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive("Zero eq", 4'd0, 32'hABCD, 32'hABCD, 1'b0, 32'h1579A, 1'b1, 1'b0, 1'b0);

        launch("MULTU max", 4'd11, 32'hFFFFFFFF, 32'd2);
        wait_done("MULTU max");
        drive("MULTU MFHI", 4'd13, 0, 0, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0);
        drive("MULTU MFLO", 4'd14, 0, 0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);

        launch("DIVU 100/7", 4'd12, 32'd100, 32'd7);
        wait_done("DIVU 100/7");
        drive("DIVU LO", 4'd14, 0, 0, 1'b0, 32'd14, 1'b0, 1'b0, 1'b0);
        drive("DIVU HI", 4'd13, 0, 0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

        launch("DIVU by 0", 4'd12, 32'd100, 32'd0);
        wait_done("DIVU by 0");
        drive("DIV0 LO", 4'd14, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        drive("DIV0 HI", 4'd13, 0, 0, 1'b0, 32'd100, 1'b0, 1'b0, 1'b0);

        // second start mid-multiply must be dropped; HI/LO stay old while busy
        launch("repulse", 4'd11, 32'h00012345, 32'h00006789);
        drive("busy MFHI", 4'd13, 0, 0, 1'b0, 32'd100, 1'b0, 1'b1, 1'b1);
        drive("busy MFLO", 4'd14, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
        drive("repulse start", 4'd11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, '0, 1'b0, 1'b1, 1'b1);
        wait_done("repulse");
        comb("repulse MFHI", 4'd13, 0, 0);
        comb("repulse MFLO", 4'd14, 0, 0);
        chk("repulse LO value", 64'(m_lo), 64'(32'h12345 * 32'h6789));

        launch("reset mid DIVU", 4'd12, 32'hFFFF0000, 32'd3);
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        dq.delete();
        m_hi = '0;
        m_lo = '0;
        drive("rst MFHI", 4'd13, 0, 0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        drive("rst MFLO", 4'd14, 0, 0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        launch("DIVU after rst", 4'd12, 32'd100, 32'd7);
        wait_done("DIVU after rst");
        drive("after rst LO", 4'd14, 0, 0, 1'b0, 32'd14, 1'b0, 1'b0, 1'b0);
        drive("after rst HI", 4'd13, 0, 0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            op = (i % 2 == 0) ? 4'd11 : 4'd12;
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 300)) : $urandom);
            launch("rand muldiv", op, a, b);
            wait_done("rand muldiv");
            comb("rand MFHI", 4'd13, $urandom, $urandom);
            comb("rand MFLO", 4'd14, $urandom, $urandom);
        end

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op == 4'd11 || op == 4'd12) op = 4'd15;
            a = $urandom;
            b = (i % 7 == 0) ? a : $urandom;
            if (i % 5 == 0) a = {1'b1, a[W-2:0]};
            comb("rand comb", op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal values: 8, 16, 32, 64).
REQ-002 SHALL have parameter OPW, default 4, ALUOp width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port A, input, WIDTH, operand A.
REQ-006 SHALL have port B, input, WIDTH, operand B; low clog2(WIDTH) bits are the shift amount.
REQ-007 SHALL have port ALUOp, input, OPW, operation select.
REQ-008 SHALL have port start, input, 1, launches MULTU/DIVU when sampled high in IDLE.
REQ-009 SHALL have port C, output, WIDTH, result.
REQ-010 SHALL have port Zero, output, 1, equal to 1 when A == B, combinational.
REQ-011 SHALL have port busy, output, 1, high while a multiply or divide iterates.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when HI/LO are updated.

Function
REQ-013 SHALL decode ALUOp as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULTU, 12 DIVU, 13 MFHI, 14 MFLO, 15 NOP (C = A).
REQ-014 SHALL produce C combinationally, in the same cycle, for ops 0-10 and 13-15; ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
REQ-015 SHALL drive SLT/SLTU results as 1 or 0 zero-extended to WIDTH.
REQ-016 SHALL shift A by B[clog2(WIDTH)-1:0] for SLL/SRL/SRA; SRA replicates A[WIDTH-1].
REQ-017 SHALL drive C = 0 for ALUOp 11 and 12.
REQ-018 SHALL hold internal registers HI and LO, each WIDTH bits; MFHI drives C = HI and MFLO drives C = LO.
REQ-019 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-020 SHALL transition IDLE->MUL when start = 1 and ALUOp = 11, capturing A and B.
REQ-021 SHALL transition IDLE->DIV when start = 1 and ALUOp = 12, capturing A and B.
REQ-022 SHALL ignore start in IDLE when ALUOp is any other value.
REQ-023 SHALL perform unsigned shift-add multiply, one bit per cycle, for exactly WIDTH cycles in MUL, giving a 2*WIDTH product split {HI,LO}.
REQ-024 SHALL perform unsigned restoring divide, one bit per cycle, for exactly WIDTH cycles in DIV, giving LO = quotient and HI = remainder.
REQ-025 SHALL, on divide by zero, take the same WIDTH-cycle latency and yield LO = all ones and HI = A.
REQ-026 SHALL transition MUL/DIV->DONE after the last iteration; DONE writes HI/LO, asserts done for one cycle, then returns to IDLE.
REQ-027 SHALL give a start-to-done latency of WIDTH+1 cycles, with done in cycle WIDTH+1 after the start edge.
REQ-028 SHALL assert busy in MUL and DIV only.
REQ-029 SHALL ignore start while busy or in DONE; captured operands are unaffected by later A/B changes.
REQ-030 SHALL keep HI/LO at their old values until DONE; MFHI/MFLO during busy return the old values.
REQ-031 SHALL return the new HI/LO on MFHI/MFLO in the cycle after done.
REQ-032 SHALL size the iteration counter as clog2(WIDTH)+1 bits, with no wrap before the terminal count.

Reset
REQ-033 SHALL, on rst = 1 at any time including mid-operation, go to IDLE, clear HI, LO, counter and captured operands to 0, and drive busy = 0 and done = 0.
REQ-034 SHALL drive C from the combinational decode during reset; C = HI = 0 for MFHI.
REQ-035 SHALL accept a start in the first clock edge after rst deasserts.

Structure
REQ-036 SHALL place the ALUOp encodings (REQ-013) and the FSM state encoding in shared package alu_pkg, included by the control unit.
REQ-037 SHALL implement the iterative MUL/DIV datapath, counter and FSM in sub-module muldiv_seq; combinational ops stay in alu_muldiv.

Verification
REQ-038 SHALL cover SRA with WIDTH=32, A=0x80000010, B=4, ALUOp=10 -> C=0xF8000001 in the same cycle.
REQ-039 SHALL cover SLT vs SLTU with A=0xFFFFFFFF, B=1 -> SLT C=1, SLTU C=0; Zero=0.
REQ-040 SHALL cover MULTU with A=0xFFFFFFFF, B=2, start pulse -> busy for 32 cycles, done at cycle 33, then MFHI=0x00000001 and MFLO=0xFFFFFFFE.
REQ-041 SHALL cover DIVU with A=100, B=7 -> LO=14, HI=2; with B=0 -> LO=0xFFFFFFFF, HI=100 after the same latency.
REQ-042 SHALL cover start re-pulsed at cycle 5 of a MULTU -> ignored, single done, HI/LO unchanged by the second request.
REQ-043 SHALL cover rst asserted at cycle 10 of a DIVU -> busy=0 and HI=LO=0 immediately, no done; a new DIVU afterwards completes correctly.
